// File: rtl/operand_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : operand_unpacker
// Description : FPU front end. Splits two IEEE-754 single-precision words into
//               raw sign/exponent/fraction fields, classifies each operand and
//               produces a normalized unbiased exponent plus a 1.23 fraction.
//               Denormals leave this block already left-aligned.
//               Two-stage valid/ready pipeline with full-throughput stalls.
// Ports       : clk, reset (sync, active-high)
//               in_valid / in_ready / operand_a / operand_b   : input pair
//               out_valid / out_ready                         : output handshake
//               operand_sign_*, operand_exponent_*,
//               operand_fraction_*                            : raw fields
//               norm_exponent_* (10b two's-compl), norm_fraction_* (1.23)
//               class_* : one-hot {snan, qnan, inf, normal, denormal, zero}
// Revision    : 1.0  initial release
// ============================================================================
module operand_unpacker #(
    parameter bit DENORMAL_FLUSH = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        operand_sign_a,
    output logic        operand_sign_b,
    output logic [7:0]  operand_exponent_a,
    output logic [7:0]  operand_exponent_b,
    output logic [23:0] operand_fraction_a,
    output logic [23:0] operand_fraction_b,
    output logic [9:0]  norm_exponent_a,
    output logic [9:0]  norm_exponent_b,
    output logic [23:0] norm_fraction_a,
    output logic [23:0] norm_fraction_b,
    output logic [5:0]  class_a,
    output logic [5:0]  class_b
);

    // One-hot class encodings
    localparam logic [5:0] c_CLS_SNAN   = 6'b100000;
    localparam logic [5:0] c_CLS_QNAN   = 6'b010000;
    localparam logic [5:0] c_CLS_INF    = 6'b001000;
    localparam logic [5:0] c_CLS_NORMAL = 6'b000100;
    localparam logic [5:0] c_CLS_DENORM = 6'b000010;
    localparam logic [5:0] c_CLS_ZERO   = 6'b000001;

    // -127 in 10-bit two's complement, and +128
    localparam logic [9:0] c_EXP_MIN    = 10'h381;
    localparam logic [9:0] c_EXP_SPEC   = 10'h080;
    localparam logic [9:0] c_BIAS       = 10'd127;

    // ------------------------------------------------------------------------
    // Classification of one operand word
    // ------------------------------------------------------------------------
    function automatic logic [5:0] classify(input logic [31:0] w);
        logic [7:0]  e;
        logic [22:0] f;
        logic [5:0]  c;
        e = w[30:23];
        f = w[22:0];
        if (e == 8'h00) begin
            // Flushed denormals become zeros here; raw fields stay untouched
            if ((f == 23'd0) || DENORMAL_FLUSH)
                c = c_CLS_ZERO;
            else
                c = c_CLS_DENORM;
        end else if (e != 8'hFF) begin
            c = c_CLS_NORMAL;
        end else if (f == 23'd0) begin
            c = c_CLS_INF;
        end else if (f[22]) begin
            c = c_CLS_QNAN;
        end else begin
            c = c_CLS_SNAN;
        end
        return c;
    endfunction

    // Leading-zero count of the 23-bit fraction field (23 when all zero)
    function automatic logic [4:0] lzc23(input logic [22:0] f);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 22; i >= 0; i--) begin
            if (!found) begin
                if (f[i])
                    found = 1'b1;
                else
                    n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------------
    // Normalization: returns {norm_exponent[9:0], norm_fraction[23:0]}
    // ------------------------------------------------------------------------
    function automatic logic [33:0] normalize(input logic [31:0] w,
                                              input logic [5:0]  cls,
                                              input logic [4:0]  lz);
        logic [23:0] frac_h;
        logic [23:0] frac_sh;
        logic [4:0]  sh;
        logic [9:0]  ne;
        logic [23:0] nf;
        frac_h  = {(w[30:23] != 8'h00), w[22:0]};
        // Shift the first set bit of the denormal fraction into bit 23
        sh      = lz + 5'd1;
        frac_sh = {1'b0, w[22:0]} << sh;
        case (cls)
            c_CLS_ZERO: begin
                ne = c_EXP_MIN;
                nf = 24'h000000;
            end
            c_CLS_DENORM: begin
                ne = c_EXP_MIN - {5'd0, lz};
                nf = frac_sh;
            end
            c_CLS_NORMAL: begin
                ne = {2'b00, w[30:23]} - c_BIAS;
                nf = frac_h;
            end
            default: begin
                // inf / qnan / snan
                ne = c_EXP_SPEC;
                nf = frac_h;
            end
        endcase
        return {ne, nf};
    endfunction

    // ------------------------------------------------------------------------
    // Handshake: each stage advances when it is empty or the next one moves
    // ------------------------------------------------------------------------
    logic s1_valid_q;
    logic s2_valid_q;
    logic adv1;
    logic adv2;

    assign adv2      = !s2_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;

    // ------------------------------------------------------------------------
    // Stage 1: capture words, classify, count leading zeros
    // ------------------------------------------------------------------------
    logic [31:0] s1_word_a_q;
    logic [31:0] s1_word_b_q;
    logic [5:0]  s1_class_a_q;
    logic [5:0]  s1_class_b_q;
    logic [4:0]  s1_lz_a_q;
    logic [4:0]  s1_lz_b_q;

    logic [5:0]  class_a_d;
    logic [5:0]  class_b_d;
    logic [4:0]  lz_a_d;
    logic [4:0]  lz_b_d;

    always_comb begin
        class_a_d = classify(operand_a);
        class_b_d = classify(operand_b);
        lz_a_d    = lzc23(operand_a[22:0]);
        lz_b_d    = lzc23(operand_b[22:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_word_a_q  <= 32'd0;
            s1_word_b_q  <= 32'd0;
            s1_class_a_q <= 6'd0;
            s1_class_b_q <= 6'd0;
            s1_lz_a_q    <= 5'd0;
            s1_lz_b_q    <= 5'd0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_word_a_q  <= operand_a;
                s1_word_b_q  <= operand_b;
                s1_class_a_q <= class_a_d;
                s1_class_b_q <= class_b_d;
                s1_lz_a_q    <= lz_a_d;
                s1_lz_b_q    <= lz_b_d;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: shift/subtract and register every output
    // ------------------------------------------------------------------------
    logic [33:0] norm_a_d;
    logic [33:0] norm_b_d;

    always_comb begin
        norm_a_d = normalize(s1_word_a_q, s1_class_a_q, s1_lz_a_q);
        norm_b_d = normalize(s1_word_b_q, s1_class_b_q, s1_lz_b_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q         <= 1'b0;
            operand_sign_a     <= 1'b0;
            operand_sign_b     <= 1'b0;
            operand_exponent_a <= 8'd0;
            operand_exponent_b <= 8'd0;
            operand_fraction_a <= 24'd0;
            operand_fraction_b <= 24'd0;
            norm_exponent_a    <= 10'd0;
            norm_exponent_b    <= 10'd0;
            norm_fraction_a    <= 24'd0;
            norm_fraction_b    <= 24'd0;
            class_a            <= 6'd0;
            class_b            <= 6'd0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                operand_sign_a     <= s1_word_a_q[31];
                operand_sign_b     <= s1_word_b_q[31];
                operand_exponent_a <= s1_word_a_q[30:23];
                operand_exponent_b <= s1_word_b_q[30:23];
                operand_fraction_a <= {(s1_word_a_q[30:23] != 8'h00), s1_word_a_q[22:0]};
                operand_fraction_b <= {(s1_word_b_q[30:23] != 8'h00), s1_word_b_q[22:0]};
                norm_exponent_a    <= norm_a_d[33:24];
                norm_exponent_b    <= norm_b_d[33:24];
                norm_fraction_a    <= norm_a_d[23:0];
                norm_fraction_b    <= norm_b_d[23:0];
                class_a            <= s1_class_a_q;
                class_b            <= s1_class_b_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_unpacker
// Description : Directed self-checking bench for operand_unpacker, covering
//               classification, normalization, flush mode, backpressure and
//               mid-flight reset. One DUT per DENORMAL_FLUSH setting.
// Revision    : 1.0  initial release
// ============================================================================
module tb_operand_unpacker;

    localparam logic [5:0] c_SNAN   = 6'b100000;
    localparam logic [5:0] c_QNAN   = 6'b010000;
    localparam logic [5:0] c_INF    = 6'b001000;
    localparam logic [5:0] c_NORMAL = 6'b000100;
    localparam logic [5:0] c_DENORM = 6'b000010;
    localparam logic [5:0] c_ZERO   = 6'b000001;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] operand_a, operand_b;
    logic        operand_sign_a, operand_sign_b;
    logic [7:0]  operand_exponent_a, operand_exponent_b;
    logic [23:0] operand_fraction_a, operand_fraction_b;
    logic [9:0]  norm_exponent_a, norm_exponent_b;
    logic [23:0] norm_fraction_a, norm_fraction_b;
    logic [5:0]  class_a, class_b;

    logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [31:0] f_operand_a, f_operand_b;
    logic        f_sign_a, f_sign_b;
    logic [7:0]  f_exp_a, f_exp_b;
    logic [23:0] f_frac_a, f_frac_b;
    logic [9:0]  f_nexp_a, f_nexp_b;
    logic [23:0] f_nfrac_a, f_nfrac_b;
    logic [5:0]  f_class_a, f_class_b;

    int n_total = 0;
    int n_pass  = 0;

    operand_unpacker #(.DENORMAL_FLUSH(1'b0)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_sign_a(operand_sign_a), .operand_sign_b(operand_sign_b),
        .operand_exponent_a(operand_exponent_a), .operand_exponent_b(operand_exponent_b),
        .operand_fraction_a(operand_fraction_a), .operand_fraction_b(operand_fraction_b),
        .norm_exponent_a(norm_exponent_a), .norm_exponent_b(norm_exponent_b),
        .norm_fraction_a(norm_fraction_a), .norm_fraction_b(norm_fraction_b),
        .class_a(class_a), .class_b(class_b)
    );

    operand_unpacker #(.DENORMAL_FLUSH(1'b1)) u_dut_flush (
        .clk(clk), .reset(reset),
        .in_valid(f_in_valid), .in_ready(f_in_ready),
        .operand_a(f_operand_a), .operand_b(f_operand_b),
        .out_valid(f_out_valid), .out_ready(f_out_ready),
        .operand_sign_a(f_sign_a), .operand_sign_b(f_sign_b),
        .operand_exponent_a(f_exp_a), .operand_exponent_b(f_exp_b),
        .operand_fraction_a(f_frac_a), .operand_fraction_b(f_frac_b),
        .norm_exponent_a(f_nexp_a), .norm_exponent_b(f_nexp_b),
        .norm_fraction_a(f_nfrac_a), .norm_fraction_b(f_nfrac_b),
        .class_a(f_class_a), .class_b(f_class_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input string tag, input logic s, input logic [7:0] e,
                         input logic [23:0] f, input logic [9:0] ne,
                         input logic [23:0] nf, input logic [5:0] c);
        chk({tag, ".sign_a"},  {63'd0, operand_sign_a},     {63'd0, s});
        chk({tag, ".exp_a"},   {56'd0, operand_exponent_a}, {56'd0, e});
        chk({tag, ".frac_a"},  {40'd0, operand_fraction_a}, {40'd0, f});
        chk({tag, ".nexp_a"},  {54'd0, norm_exponent_a},    {54'd0, ne});
        chk({tag, ".nfrac_a"}, {40'd0, norm_fraction_a},    {40'd0, nf});
        chk({tag, ".class_a"}, {58'd0, class_a},            {58'd0, c});
    endtask

    task automatic exp_b(input string tag, input logic s, input logic [7:0] e,
                         input logic [23:0] f, input logic [9:0] ne,
                         input logic [23:0] nf, input logic [5:0] c);
        chk({tag, ".sign_b"},  {63'd0, operand_sign_b},     {63'd0, s});
        chk({tag, ".exp_b"},   {56'd0, operand_exponent_b}, {56'd0, e});
        chk({tag, ".frac_b"},  {40'd0, operand_fraction_b}, {40'd0, f});
        chk({tag, ".nexp_b"},  {54'd0, norm_exponent_b},    {54'd0, ne});
        chk({tag, ".nfrac_b"}, {40'd0, norm_fraction_b},    {40'd0, nf});
        chk({tag, ".class_b"}, {58'd0, class_b},            {58'd0, c});
    endtask

    // Stream pair i: a = 0x40000000|i (frac field i), b = 0x3F800000|i
    task automatic drive_stream(input int i);
        in_valid  = 1'b1;
        operand_a = 32'h40000000 | i;
        operand_b = 32'h3F800000 | i;
    endtask

    task automatic chk_stream(input string tag, input int i);
        chk({tag, ".vld"},    {63'd0, out_valid},          64'd1);
        chk({tag, ".frac_a"}, {40'd0, operand_fraction_a}, 64'h800000 | i);
        chk({tag, ".frac_b"}, {40'd0, operand_fraction_b}, 64'h800000 | i);
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; operand_a = 32'd0; operand_b = 32'd0;
        f_in_valid = 1'b0; f_out_ready = 1'b1; f_operand_a = 32'd0; f_operand_b = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // ---- reset state
        chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst.in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst.class_a",   {58'd0, class_a},   64'd0);
        chk("rst.nexp_b",    {54'd0, norm_exponent_b}, 64'd0);
        chk("rst.frac_a",    {40'd0, operand_fraction_a}, 64'd0);

        // ---- four directed pairs back to back
        in_valid = 1'b1; operand_a = 32'h3F800000; operand_b = 32'hC0000000;
        step();
        chk("p1.latency", {63'd0, out_valid}, 64'd0);
        operand_a = 32'h00000001; operand_b = 32'h00400000;
        step();
        chk("p1.vld", {63'd0, out_valid}, 64'd1);
        exp_a("p1", 1'b0, 8'h7F, 24'h800000, 10'h000, 24'h800000, c_NORMAL);
        exp_b("p1", 1'b1, 8'h80, 24'h800000, 10'h001, 24'h800000, c_NORMAL);
        operand_a = 32'h7FC00000; operand_b = 32'h7F800001;
        step();
        chk("p2.vld", {63'd0, out_valid}, 64'd1);
        exp_a("p2", 1'b0, 8'h00, 24'h000001, 10'h36B, 24'h800000, c_DENORM);
        exp_b("p2", 1'b0, 8'h00, 24'h400000, 10'h381, 24'h800000, c_DENORM);
        operand_a = 32'hFF800000; operand_b = 32'h80000000;
        step();
        chk("p3.vld", {63'd0, out_valid}, 64'd1);
        exp_a("p3", 1'b0, 8'hFF, 24'hC00000, 10'h080, 24'hC00000, c_QNAN);
        exp_b("p3", 1'b0, 8'hFF, 24'h800001, 10'h080, 24'h800001, c_SNAN);
        in_valid = 1'b0;
        step();
        chk("p4.vld", {63'd0, out_valid}, 64'd1);
        exp_a("p4", 1'b1, 8'hFF, 24'h800000, 10'h080, 24'h800000, c_INF);
        exp_b("p4", 1'b1, 8'h00, 24'h000000, 10'h381, 24'h000000, c_ZERO);
        step();
        chk("p4.drain", {63'd0, out_valid}, 64'd0);

        // ---- flush-mode instance
        f_in_valid = 1'b1; f_operand_a = 32'h80000001; f_operand_b = 32'h00400000;
        step();
        f_in_valid = 1'b0;
        step();
        chk("fl.vld",     {63'd0, f_out_valid}, 64'd1);
        chk("fl.class_a", {58'd0, f_class_a},   {58'd0, c_ZERO});
        chk("fl.sign_a",  {63'd0, f_sign_a},    64'd1);
        chk("fl.exp_a",   {56'd0, f_exp_a},     64'd0);
        chk("fl.frac_a",  {40'd0, f_frac_a},    64'h000001);
        chk("fl.nfrac_a", {40'd0, f_nfrac_a},   64'd0);
        chk("fl.nexp_a",  {54'd0, f_nexp_a},    64'h381);
        chk("fl.class_b", {58'd0, f_class_b},   {58'd0, c_ZERO});
        chk("fl.frac_b",  {40'd0, f_frac_b},    64'h400000);
        chk("fl.nfrac_b", {40'd0, f_nfrac_b},   64'd0);

        // ---- stream 4 pairs with 3 cycles of backpressure after first output
        drive_stream(0);
        step();
        drive_stream(1);
        step();
        chk_stream("st.e2", 0);
        chk("st.rdy_e2", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
        drive_stream(2);
        #1;
        chk("st.rdy_drop", {63'd0, in_ready}, 64'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk_stream("st.hold", 0);
            chk("st.hold_rdy", {63'd0, in_ready}, 64'd0);
            chk("st.hold_nexp", {54'd0, norm_exponent_a}, 64'h001);
        end
        step();
        chk_stream("st.hold3", 0);
        out_ready = 1'b1;
        #1;
        chk("st.rdy_back", {63'd0, in_ready}, 64'd1);
        step();
        chk_stream("st.e6", 1);
        drive_stream(3);
        step();
        chk_stream("st.e7", 2);
        in_valid = 1'b0;
        step();
        chk_stream("st.e8", 3);
        step();
        chk("st.drain", {63'd0, out_valid}, 64'd0);

        // ---- reset with two pairs in flight
        in_valid = 1'b1; operand_a = 32'h3F800000; operand_b = 32'h00000000;
        step();
        operand_a = 32'h40400000;
        step();
        chk("rm.full", {63'd0, out_valid}, 64'd1);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        chk("rm.vld",  {63'd0, out_valid}, 64'd0);
        chk("rm.frac", {40'd0, operand_fraction_a}, 64'd0);
        reset = 1'b0;
        #1;
        chk("rm.rdy", {63'd0, in_ready}, 64'd1);
        step();
        chk("rm.nostale", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        in_valid = 1'b1; operand_a = 32'h41200000; operand_b = 32'h00000000;
        step();
        chk("rm.lat", {63'd0, out_valid}, 64'd0);
        in_valid = 1'b0;
        step();
        chk("rm.new_vld", {63'd0, out_valid}, 64'd1);
        exp_a("rm", 1'b0, 8'h82, 24'hA00000, 10'h003, 24'hA00000, c_NORMAL);
        step();
        chk("rm.drain", {63'd0, out_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
